// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encodings and default widths/polynomial.
package bist_pkg;

  // Default MISR signature width and counter width (controller ERR_BITS follows CNT_BITS_DEF)
  localparam int unsigned SIG_BITS_DEF = 16;
  localparam int unsigned CNT_BITS_DEF = 16;

  // Default Galois feedback mask: x^16+x^14+x^13+x^11+1
  localparam logic [15:0] POLY_DEF = 16'hB400;

  // Session state encoding {IDLE, RUN, CMP, DONE}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/misr.sv
// Galois-style multiple-input signature register with synchronous clear.
module misr
  import bist_pkg::*;
#(
  parameter int unsigned W    = SIG_BITS_DEF,
  parameter int unsigned IN   = 4,
  parameter logic [W-1:0] POLY = W'(POLY_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [IN-1:0] d,
  output logic [W-1:0]  sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  // Next signature: clear wins, otherwise one shift/feedback/xor step when enabled
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = (sig_q >> 1) ^ (sig_q[0] ? POLY : W'(0)) ^ W'(d);
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_sig_analyzer.sv
// BIST response analyzer: compacts CUT and fault-free responses into two MISRs,
// counts per-pattern mismatches and compares signatures after the last pattern.
module misr_sig_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned         OUT_BITS = 4,
  parameter int unsigned         SIG_BITS = SIG_BITS_DEF,
  parameter logic [SIG_BITS-1:0] POLY     = SIG_BITS'(POLY_DEF),
  parameter int unsigned         CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                START,
  input  logic                VALID,
  input  logic                LAST,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  output logic [SIG_BITS-1:0] SIG_CUT,
  output logic [SIG_BITS-1:0] SIG_FF,
  output logic [CNT_BITS-1:0] SAMPLES,
  output logic [CNT_BITS-1:0] MISMATCHES,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS
);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] samples_q, samples_d;
  logic [CNT_BITS-1:0] mism_q, mism_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                misr_clr_c;
  logic                misr_en_c;
  logic [SIG_BITS-1:0] sig_cut;
  logic [SIG_BITS-1:0] sig_ff;

  // Signature register for the fault-injected CUT response
  misr #(.W(SIG_BITS), .IN(OUT_BITS), .POLY(POLY)) u_misr_cut (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr_c),
    .en  (misr_en_c),
    .d   (CUT_OP),
    .sig (sig_cut)
  );

  // Signature register for the fault-free reference response
  misr #(.W(SIG_BITS), .IN(OUT_BITS), .POLY(POLY)) u_misr_ff (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr_c),
    .en  (misr_en_c),
    .d   (FF_OP),
    .sig (sig_ff)
  );

  // Next-state, counter and verdict logic; START overrides everything and drops any sample
  always_comb begin
    state_d    = state_q;
    samples_d  = samples_q;
    mism_d     = mism_q;
    done_d     = done_q;
    pass_d     = pass_q;
    misr_clr_c = 1'b0;
    misr_en_c  = 1'b0;

    if (START) begin
      misr_clr_c = 1'b1;
      samples_d  = '0;
      mism_d     = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (VALID) begin
            misr_en_c = 1'b1;
            if (samples_q != '1) begin
              samples_d = samples_q + CNT_BITS'(1);
            end
            if ((CUT_OP != FF_OP) && (mism_q != '1)) begin
              mism_d = mism_q + CNT_BITS'(1);
            end
            if (LAST) begin
              state_d = ST_CMP;
            end
          end
        end
        ST_CMP: begin
          pass_d  = (sig_cut == sig_ff);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_CMP);
  end

  // State, counters and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      samples_q <= '0;
      mism_q    <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      mism_q    <= mism_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
    end
  end

  assign SIG_CUT    = sig_cut;
  assign SIG_FF     = sig_ff;
  assign SAMPLES    = samples_q;
  assign MISMATCHES = mism_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// Directed bench for misr_sig_analyzer: a vector table plus hand-written corner sequences.
module tb_misr_sig_analyzer;

  logic        clk;
  logic        rst;
  logic        START;
  logic        VALID;
  logic        LAST;
  logic [3:0]  CUT_OP;
  logic [3:0]  FF_OP;
  logic [15:0] SIG_CUT;
  logic [15:0] SIG_FF;
  logic [15:0] SAMPLES;
  logic [15:0] MISMATCHES;
  logic        BUSY;
  logic        DONE;
  logic        PASS;

  int n_cmp;
  int n_err;

  typedef struct {
    logic        start;
    logic        valid;
    logic        last;
    logic [3:0]  cut;
    logic [3:0]  ff;
    logic [15:0] e_sc;
    logic [15:0] e_sf;
    logic [15:0] e_smp;
    logic [15:0] e_mm;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
  } vec_t;

  vec_t tbl[14];

  misr_sig_analyzer dut (
    .clk        (clk),
    .rst        (rst),
    .START      (START),
    .VALID      (VALID),
    .LAST       (LAST),
    .CUT_OP     (CUT_OP),
    .FF_OP      (FF_OP),
    .SIG_CUT    (SIG_CUT),
    .SIG_FF     (SIG_FF),
    .SAMPLES    (SAMPLES),
    .MISMATCHES (MISMATCHES),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PASS       (PASS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] sc, input logic [15:0] sf,
                         input logic [15:0] smp, input logic [15:0] mm,
                         input logic busy, input logic done, input logic pass);
    chk({tag, ".SIG_CUT"},    32'(SIG_CUT),    32'(sc));
    chk({tag, ".SIG_FF"},     32'(SIG_FF),     32'(sf));
    chk({tag, ".SAMPLES"},    32'(SAMPLES),    32'(smp));
    chk({tag, ".MISMATCHES"}, 32'(MISMATCHES), 32'(mm));
    chk({tag, ".BUSY"},       32'(BUSY),       32'(busy));
    chk({tag, ".DONE"},       32'(DONE),       32'(done));
    chk({tag, ".PASS"},       32'(PASS),       32'(pass));
  endtask

  // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge
  task automatic step(input logic s, input logic v, input logic l,
                      input logic [3:0] c, input logic [3:0] f);
    @(negedge clk);
    START  = s;
    VALID  = v;
    LAST   = l;
    CUT_OP = c;
    FF_OP  = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [3:0] d);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ {12'h000, d};
  endfunction

  initial begin
    logic [15:0] m_cut;
    logic [15:0] m_ff;
    logic [3:0]  cv;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b0;
    START  = 1'b0;
    VALID  = 1'b0;
    LAST   = 1'b0;
    CUT_OP = 4'h0;
    FF_OP  = 4'h0;

    //                start valid last cut  ff    SIG_CUT   SIG_FF    SAMPLES   MISM      busy done pass
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 16'h0005, 16'h0005, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0005, 16'h0005, 16'd1, 16'd0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h7, 4'h9, 16'h0005, 16'h0005, 16'd1, 16'd0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 16'h0005, 16'h0005, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hA, 4'h3, 16'h0005, 16'h0005, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h3, 16'hB401, 16'hB401, 16'd2, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'hB401, 16'hB401, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h5, 4'h5, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h2, 16'h0001, 16'h0002, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'h2, 4'h2, 16'hB402, 16'h0003, 16'd2, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'hB402, 16'h0003, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 16'hB402, 16'h0003, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0};

    // Reset held with random inputs: everything stays zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      START  = 1'($urandom_range(0, 1));
      VALID  = 1'($urandom_range(0, 1));
      LAST   = 1'($urandom_range(0, 1));
      CUT_OP = 4'($urandom_range(0, 15));
      FF_OP  = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk_all($sformatf("rst_held%0d", i), 16'h0, 16'h0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    START = 1'b0;
    rst   = 1'b1;
    // Released into IDLE: VALID/LAST must be ignored
    step(1'b0, 1'b1, 1'b1, 4'h6, 4'h9);
    chk_all("idle_ignore", 16'h0, 16'h0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Table-driven sessions
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].start, tbl[i].valid, tbl[i].last, tbl[i].cut, tbl[i].ff);
      chk_all($sformatf("vec%0d", i), tbl[i].e_sc, tbl[i].e_sf, tbl[i].e_smp, tbl[i].e_mm,
              tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pass);
    end

    // 16 samples, single differing response on sample 7
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    m_cut = 16'h0;
    m_ff  = 16'h0;
    for (int i = 0; i < 16; i++) begin
      cv = (i == 7) ? (4'(i) ^ 4'h1) : 4'(i);
      m_cut = mstep(m_cut, cv);
      m_ff  = mstep(m_ff, 4'(i));
      step(1'b0, 1'b1, (i == 15), cv, 4'(i));
    end
    chk_all("sixteen_pre", m_cut, m_ff, 16'd16, 16'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk_all("sixteen_done", m_cut, m_ff, 16'd16, 16'd1, 1'b0, 1'b1, 1'b0);
    chk("sixteen_sig_differ", 32'(SIG_CUT != SIG_FF), 32'd1);

    // START+VALID together drops the sample; then reset mid-RUN clears immediately
    step(1'b1, 1'b1, 1'b0, 4'h5, 4'h5);
    chk_all("start_valid", 16'h0, 16'h0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h5, 4'h4);
    chk_all("run_sample", 16'h0005, 16'h0004, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    VALID = 1'b0;
    rst   = 1'b0;
    #1;
    chk_all("async_rst", 16'h0, 16'h0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 4'h5, 4'h3);
    chk_all("post_rst_idle", 16'h0, 16'h0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h9, 4'h9);
    chk_all("restart", 16'h0009, 16'h0009, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    START = 1'b0;
    VALID = 1'b0;
    LAST  = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
